// File: rtl/ql_carry_chain_bist.sv
// Carry-chain BIST: drives p/g/ci into an N-stage XOR/MUX2 carry chain,
// compares {co, sum} with a golden ripple model and reports the results.
module ql_carry_chain_bist #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned NUM_VECT = 16,
  parameter int unsigned SETTLE   = 1,
  parameter logic [31:0] SEED     = 32'hACE1_0001
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_cnt,
  output logic [15:0]      first_fail_idx,
  output logic [WIDTH-1:0] p_o,
  output logic [WIDTH-1:0] g_o,
  output logic             ci_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             co_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [15:0] LAST_IDX  = 16'(NUM_VECT - 1);
  localparam logic [3:0]  WAIT_LAST = 4'((SETTLE > 1) ? (SETTLE - 2) : 0);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_err;
  logic [15:0]      r_ffi;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_g;
  logic             r_ci;
  logic [WIDTH:0]   r_exp;
  logic [31:0]      r_lfsr;
  logic [15:0]      r_idx;
  logic [3:0]       r_wait;

  logic [WIDTH-1:0] w_vp;
  logic [WIDTH-1:0] w_vg;
  logic             w_vci;
  logic [WIDTH:0]   w_gold;
  logic [31:0]      w_lfsr_nxt;
  logic             w_last;
  logic             w_mismatch;

  // Reference ripple: sum[k] = p[k]^c[k], c[k+1] = p[k] ? c[k] : g[k]; returns {co, sum}
  function automatic logic [WIDTH:0] ripple(input logic [WIDTH-1:0] p,
                                             input logic [WIDTH-1:0] g,
                                             input logic             ci);
    logic             c;
    logic [WIDTH-1:0] s;
    c = ci;
    s = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      s[k] = p[k] ^ c;
      c    = p[k] ? c : g[k];
    end
    return {c, s};
  endfunction

  assign w_lfsr_nxt = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
  assign w_last     = (r_idx == LAST_IDX);
  assign w_mismatch = ({co_i, sum_i} != r_exp);
  assign w_gold     = ripple(w_vp, w_vg, w_vci);

  // Select the vector for the current index: three fixed patterns, then LFSR bits
  always_comb begin
    w_vp  = r_lfsr[WIDTH-1:0];
    w_vg  = r_lfsr[2*WIDTH-1:WIDTH];
    w_vci = r_lfsr[31];
    if (r_idx == 16'd0) begin
      w_vp  = '1;
      w_vg  = '0;
      w_vci = 1'b1;
    end else if (r_idx == 16'd1) begin
      w_vp  = '0;
      w_vg  = '1;
      w_vci = 1'b0;
    end else if (r_idx == 16'd2) begin
      w_vp  = '1;
      w_vg  = '0;
      w_vci = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = (SETTLE > 1) ? S_WAIT : S_CHECK;
      S_WAIT:   if (r_wait == WAIT_LAST) w_state_nxt = S_CHECK;
      S_CHECK:  w_state_nxt = w_last ? S_DONE : S_LAUNCH;
      S_DONE:   if (start) w_state_nxt = S_LAUNCH;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: vector launch, response check, counters and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
      r_err  <= '0;
      r_ffi  <= '1;
      r_p    <= '0;
      r_g    <= '0;
      r_ci   <= 1'b0;
      r_exp  <= '0;
      r_lfsr <= SEED;
      r_idx  <= '0;
      r_wait <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // DONE status is first registered on the edge after the final CHECK
          if (r_state == S_DONE) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            r_pass <= (r_err == 16'd0);
          end
          if (start) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_err  <= '0;
            r_ffi  <= '1;
            r_lfsr <= SEED;
            r_idx  <= '0;
          end
        end
        S_LAUNCH: begin
          r_p    <= w_vp;
          r_g    <= w_vg;
          r_ci   <= w_vci;
          r_exp  <= w_gold;
          r_wait <= '0;
        end
        S_WAIT: begin
          r_wait <= r_wait + 4'd1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
            if (r_ffi == 16'hFFFF) r_ffi <= r_idx;
          end
          if (!w_last) begin
            r_idx  <= r_idx + 16'd1;
            r_lfsr <= w_lfsr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_cnt        = r_err;
  assign first_fail_idx = r_ffi;
  assign p_o            = r_p;
  assign g_o            = r_g;
  assign ci_o           = r_ci;

endmodule

// File: tb/tb_ql_carry_chain_bist.sv
// Directed bench for ql_carry_chain_bist: a 4-stage instance against a bench chain
// model with selectable faults, and a 1-stage short-run instance.
module tb_ql_carry_chain_bist;

  localparam int unsigned WA     = 4;
  localparam int unsigned NV_A   = 16;
  localparam logic [31:0] SEED_A = 32'hACE1_0001;

  logic clk;
  logic reset_n;
  logic start_a;
  logic start_b;
  int   fault;

  logic          busy_a, done_a, pass_a, ci_a, co_a;
  logic [15:0]   err_a, ffi_a;
  logic [WA-1:0] p_a, g_a, sum_a;

  logic          busy_b, done_b, pass_b, ci_b, co_b;
  logic [15:0]   err_b, ffi_b;
  logic [0:0]    p_b, g_b, sum_b;

  int n_total;
  int n_bad;

  // Bench chain; mode 1 forces CO low, mode 2 sticks the stage-2 MUX on g
  function automatic logic [WA:0] chain(input logic [WA-1:0] p, input logic [WA-1:0] g,
                                        input logic ci, input int mode);
    logic          c;
    logic [WA-1:0] s;
    c = ci;
    s = '0;
    for (int k = 0; k < WA; k++) begin
      s[k] = p[k] ^ c;
      if (mode == 2 && k == 2) c = g[k];
      else                     c = p[k] ? c : g[k];
    end
    if (mode == 1) c = 1'b0;
    return {c, s};
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
  endfunction

  // Expected vector {ci, g, p} for the 4-stage instance
  function automatic logic [2*WA:0] vec_a(input int k, input logic [31:0] l);
    if (k == 0) return {1'b1, 4'h0, 4'hF};
    if (k == 1) return {1'b0, 4'hF, 4'h0};
    if (k == 2) return {1'b0, 4'h0, 4'hF};
    return {l[31], l[2*WA-1:WA], l[WA-1:0]};
  endfunction

  assign {co_a, sum_a} = chain(p_a, g_a, ci_a, fault);
  assign sum_b = p_b ^ ci_b;
  assign co_b  = p_b[0] ? ci_b : g_b[0];

  ql_carry_chain_bist #(.WIDTH(WA), .NUM_VECT(NV_A), .SETTLE(1), .SEED(SEED_A)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .first_fail_idx(ffi_a),
    .p_o(p_a), .g_o(g_a), .ci_o(ci_a),
    .sum_i(sum_a), .co_i(co_a)
  );

  ql_carry_chain_bist #(.WIDTH(1), .NUM_VECT(3), .SETTLE(3), .SEED(32'hACE1_0001)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_b), .first_fail_idx(ffi_b),
    .p_o(p_b), .g_o(g_b), .ci_o(ci_b),
    .sum_i(sum_b), .co_i(co_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check_val({tag, "_busy"}, 32'(busy_a), 32'd0);
    check_val({tag, "_done"}, 32'(done_a), 32'd0);
    check_val({tag, "_pass"}, 32'(pass_a), 32'd0);
    check_val({tag, "_err"},  32'(err_a),  32'd0);
    check_val({tag, "_ffi"},  32'(ffi_a),  32'h0000FFFF);
    check_val({tag, "_pg"},   32'({ci_a, g_a, p_a}), 32'd0);
  endtask

  // Full 16-vector run on instance A; optional stray starts at cycles 5 and 10
  task automatic run_a(input string tag, input int mode, input bit extra);
    logic [31:0]   l;
    logic [2*WA:0] v;
    int            ecount;
    logic [15:0]   effi;
    l      = SEED_A;
    ecount = 0;
    effi   = 16'hFFFF;
    for (int k = 0; k < int'(NV_A); k++) begin
      v = vec_a(k, l);
      if (chain(v[WA-1:0], v[2*WA-1:WA], v[2*WA], 0) !=
          chain(v[WA-1:0], v[2*WA-1:WA], v[2*WA], mode)) begin
        ecount++;
        if (effi == 16'hFFFF) effi = 16'(k);
      end
      l = lfsr_step(l);
    end
    fault = mode;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    l = SEED_A;
    for (int n = 1; n <= 34; n++) begin
      @(posedge clk); #1;
      if ((n % 2) == 1 && n <= 31) begin
        v = vec_a((n - 1) / 2, l);
        check_val({tag, "_vec"}, 32'({ci_a, g_a, p_a}), 32'(v));
        l = lfsr_step(l);
      end
      check_val({tag, "_done_t"}, 32'(done_a), 32'(n >= 33));
      check_val({tag, "_busy_t"}, 32'(busy_a), 32'(n < 33));
      start_a = extra && (n == 4 || n == 9);
    end
    check_val({tag, "_pass"}, 32'(pass_a), 32'(ecount == 0));
    check_val({tag, "_err"},  32'(err_a),  32'(ecount));
    check_val({tag, "_ffi"},  32'(ffi_a),  32'(effi));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [2:0] eb;
    n_total = 0;
    n_bad   = 0;
    fault   = 0;
    start_a = 1'b0;
    start_b = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("rst");
    check_val("rst_b_busy", 32'(busy_b), 32'd0);
    check_val("rst_b_ffi",  32'(ffi_b),  32'h0000FFFF);
    @(negedge clk);
    reset_n = 1'b1;

    run_a("good", 0, 1'b0);
    // idx 0 expects co=1, so a stuck-low CO fails there first
    run_a("co0", 1, 1'b0);
    check_val("co0_ffi_h", 32'(ffi_a), 32'd0);
    // idx 0 ripple with c[3] taken from g[2]=0 gives sum[3]=1, co=0
    run_a("stk2", 2, 1'b0);
    check_val("stk2_ffi_h", 32'(ffi_a), 32'd0);
    run_a("restart", 0, 1'b1);
    check_val("restart_pass_h", 32'(pass_a), 32'd1);

    // Abort mid-run once vector 7 has been launched (edge 15)
    fault = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    check_val("abort_busy_pre", 32'(busy_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_a("abort");
    @(negedge clk);
    reset_n = 1'b1;
    run_a("after", 0, 1'b0);

    // Short run on the 1-stage instance: launches at edges 1, 5, 9; done at 13
    @(negedge clk);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    eb = 3'b000;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (n == 1) eb = 3'b101;
      if (n == 5) eb = 3'b010;
      if (n == 9) eb = 3'b100;
      check_val("b_vec", 32'({p_b, g_b, ci_b}), 32'(eb));
      check_val("b_done_t", 32'(done_b), 32'(n >= 13));
    end
    check_val("b_pass", 32'(pass_b), 32'd1);
    check_val("b_err",  32'(err_b),  32'd0);
    check_val("b_ffi",  32'(ffi_b),  32'h0000FFFF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
